// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - ISA constants and loader state type shared by the instruction memory.
package instr_mem_pkg;

  localparam int WORD_W   = 32;
  localparam int OPCODE_W = 7;

  localparam logic [WORD_W-1:0] NOP_WORD = 32'hC800_0000;

  localparam logic [OPCODE_W-1:0] OP_B   = 7'h60;
  localparam logic [OPCODE_W-1:0] OP_BR  = 7'h61;
  localparam logic [OPCODE_W-1:0] OP_BCC = 7'h62;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } ld_state_e;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [WORD_W-1:0] word);
    return word[WORD_W-1 -: OPCODE_W];
  endfunction

endpackage

// File: rtl/instr_mem_if.sv
// rtl/instr_mem_if.sv - fetch request/response and byte-serial program-load signals.
interface instr_mem_if #(
  parameter int DEPTH_WORDS = 1024
) ();
  localparam int ADDR_W = $clog2(DEPTH_WORDS);

  logic [31:0]     pc_addr;
  logic [31:0]     instruction;
  logic            fetch_fault;
  logic            ld_start;
  logic [7:0]      ld_byte;
  logic            ld_valid;
  logic            ld_last;
  logic            ld_ready;
  logic            ld_done;
  logic [ADDR_W:0] ld_words;

  modport master (
    output pc_addr, ld_start, ld_byte, ld_valid, ld_last,
    input  instruction, fetch_fault, ld_ready, ld_done, ld_words
  );

  modport slave (
    input  pc_addr, ld_start, ld_byte, ld_valid, ld_last,
    output instruction, fetch_fault, ld_ready, ld_done, ld_words
  );
endinterface

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - program loader FSM: assembles big-endian bytes into words and emits writes.
module instr_mem_loader
  import instr_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              ld_start_i,
  input  logic [7:0]        ld_byte_i,
  input  logic              ld_valid_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  output logic              ld_done_o,
  output logic [ADDR_W:0]   ld_words_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_idx_o,
  output logic [WORD_W-1:0] wr_data_o,
  output logic              loading_o
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH_WORDS);

  ld_state_e         state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [WORD_W-1:0] cur_word;

  // Lower bytes are zeroed as each byte lands, so a short final word is already padded.
  always_comb begin
    cur_word = asm_q;
    case (cnt_q)
      2'd0:    cur_word = {ld_byte_i, 24'h0};
      2'd1:    cur_word = {asm_q[31:24], ld_byte_i, 16'h0};
      2'd2:    cur_word = {asm_q[31:16], ld_byte_i, 8'h0};
      default: cur_word = {asm_q[31:8], ld_byte_i};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    words_d    = words_q;
    wr_en_o    = 1'b0;
    ld_ready_o = 1'b0;
    ld_done_o  = 1'b0;
    case (state_q)
      LD_IDLE: begin
        if (ld_start_i) begin
          state_d = LD_LOAD;
          cnt_d   = 2'd0;
          words_d = '0;
          asm_d   = '0;
        end
      end
      LD_LOAD: begin
        ld_ready_o = (words_q != FULL);
        if (ld_valid_i && ld_ready_o) begin
          asm_d = cur_word;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3 || ld_last_i) begin
            wr_en_o = 1'b1;
            words_d = words_q + 1'b1;
          end
          if (ld_last_i || (wr_en_o && words_d == FULL)) state_d = LD_DONE;
        end
      end
      LD_DONE: begin
        ld_done_o = 1'b1;
        state_d   = LD_IDLE;
      end
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= LD_IDLE;
      cnt_q   <= 2'd0;
      asm_q   <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      words_q <= words_d;
    end
  end

  assign ld_words_o = words_q;
  assign wr_idx_o   = words_q[ADDR_W-1:0];
  assign wr_data_o  = cur_word;
  assign loading_o  = (state_q == LD_LOAD);

endmodule

// File: rtl/instr_mem.sv
// rtl/instr_mem.sv - word-addressed instruction memory with registered fetch and program loader.
module instr_mem
  import instr_mem_pkg::*;
#(
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [WORD_W-1:0] NOP_WORD    = instr_mem_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  instr_mem_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  logic              wr_en;
  logic [ADDR_W-1:0] wr_idx;
  logic [WORD_W-1:0] wr_data;
  logic              loading;
  logic [ADDR_W-1:0] rd_idx;
  logic              misaligned, out_of_range;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic              fault_q, fault_d;

  instr_mem_loader #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_loader (
    .clk_i      (clk),
    .reset_i    (reset),
    .ld_start_i (bus.ld_start),
    .ld_byte_i  (bus.ld_byte),
    .ld_valid_i (bus.ld_valid),
    .ld_last_i  (bus.ld_last),
    .ld_ready_o (bus.ld_ready),
    .ld_done_o  (bus.ld_done),
    .ld_words_o (bus.ld_words),
    .wr_en_o    (wr_en),
    .wr_idx_o   (wr_idx),
    .wr_data_o  (wr_data),
    .loading_o  (loading)
  );

  // Contents survive reset so a program can be reloaded-free across resets.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign rd_idx       = bus.pc_addr[ADDR_W+1:2];
  assign misaligned   = |bus.pc_addr[1:0];
  assign out_of_range = |bus.pc_addr[31:ADDR_W+2];

  always_comb begin
    instr_d = NOP_WORD;
    fault_d = 1'b0;
    if (misaligned || out_of_range) begin
      fault_d = 1'b1;
    end else if (!loading) begin
      instr_d = mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP_WORD;
      fault_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      fault_q <= fault_d;
    end
  end

  assign bus.instruction = instr_q;
  assign bus.fetch_fault = fault_q;

endmodule

// File: tb/tb_instr_mem.sv
// tb/tb_instr_mem.sv - scoreboard bench for instr_mem with a 1024-word and a 4-word instance.
module tb_instr_mem;

  localparam logic [31:0] NOP = 32'hC800_0000;

  typedef enum int {K_INSTR, K_FAULT, K_READY, K_DONE, K_WORDS} kind_e;
  typedef struct {
    int          cyc;
    int          dut;
    kind_e       kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  instr_mem_if #(.DEPTH_WORDS(1024)) ifa ();
  instr_mem_if #(.DEPTH_WORDS(4))    ifb ();

  instr_mem #(.DEPTH_WORDS(1024)) dut_a (.clk(clk), .reset(rst_a), .bus(ifa.slave));
  instr_mem #(.DEPTH_WORDS(4))    dut_b (.clk(clk), .reset(rst_b), .bus(ifb.slave));

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] sample(input int d, input kind_e k);
    logic [31:0] v;
    v = 32'h0;
    if (d == 0) begin
      case (k)
        K_INSTR: v = ifa.instruction;
        K_FAULT: v = 32'(ifa.fetch_fault);
        K_READY: v = 32'(ifa.ld_ready);
        K_DONE:  v = 32'(ifa.ld_done);
        default: v = 32'(ifa.ld_words);
      endcase
    end else begin
      case (k)
        K_INSTR: v = ifb.instruction;
        K_FAULT: v = 32'(ifb.fetch_fault);
        K_READY: v = 32'(ifb.ld_ready);
        K_DONE:  v = 32'(ifb.ld_done);
        default: v = 32'(ifb.ld_words);
      endcase
    end
    return v;
  endfunction

  task automatic expect_at(input int dly, input int d, input kind_e k,
                           input logic [31:0] v, input string n);
    exp_t e;
    e.cyc = cyc + dly; e.dut = d; e.kind = k; e.val = v; e.name = n;
    sb.push_back(e);
  endtask

  // Monitor: after each rising edge, compare every expectation due this cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc <= cyc) begin
          logic [31:0] act;
          act = sample(sb[i].dut, sb[i].kind);
          checks++;
          if (sb[i].cyc < cyc || act !== sb[i].val) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d actual %h required %h",
                     sb[i].name, sb[i].dut, cyc, act, sb[i].val);
          end
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic fetch_a(input logic [31:0] pc, input logic [31:0] ins, input logic flt,
                         input string n);
    tick();
    ifa.ld_start = 1'b0; ifa.ld_valid = 1'b0; ifa.ld_last = 1'b0;
    ifa.pc_addr  = pc;
    expect_at(1, 0, K_INSTR, ins, {n, "_instr"});
    expect_at(1, 0, K_FAULT, 32'(flt), {n, "_fault"});
  endtask

  task automatic fetch_b(input logic [31:0] pc, input logic [31:0] ins, input logic flt,
                         input string n);
    tick();
    ifb.ld_start = 1'b0; ifb.ld_valid = 1'b0; ifb.ld_last = 1'b0;
    ifb.pc_addr  = pc;
    expect_at(1, 1, K_INSTR, ins, {n, "_instr"});
    expect_at(1, 1, K_FAULT, 32'(flt), {n, "_fault"});
  endtask

  task automatic load_a(input logic [7:0] bytes[$], input int nwords, input string n);
    tick();
    ifa.ld_start = 1'b1;
    ifa.pc_addr  = 32'h0;
    expect_at(1, 0, K_READY, 32'h1, {n, "_ready"});
    for (int i = 0; i < bytes.size(); i++) begin
      tick();
      ifa.ld_start = 1'b0;
      ifa.ld_valid = 1'b1;
      ifa.ld_byte  = bytes[i];
      ifa.ld_last  = (i == bytes.size() - 1);
      if (i == 0) begin
        expect_at(1, 0, K_INSTR, NOP, {n, "_stall_nop"});
        expect_at(1, 0, K_FAULT, 32'h0, {n, "_stall_fault"});
      end
    end
    expect_at(1, 0, K_DONE, 32'h1, {n, "_done"});
    expect_at(1, 0, K_READY, 32'h0, {n, "_ready_off"});
    expect_at(1, 0, K_WORDS, 32'(nwords), {n, "_words"});
  endtask

  initial begin
    logic [7:0] q[$];
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.pc_addr = 32'h2; ifa.ld_start = 1'b0; ifa.ld_byte = 8'h0; ifa.ld_valid = 1'b0; ifa.ld_last = 1'b0;
    ifb.pc_addr = 32'h2; ifb.ld_start = 1'b0; ifb.ld_byte = 8'h0; ifb.ld_valid = 1'b0; ifb.ld_last = 1'b0;
    tick(); tick();

    // Reset state
    tick();
    ifa.pc_addr = 32'h0;
    expect_at(1, 0, K_INSTR, NOP,   "rst_instr");
    expect_at(1, 0, K_FAULT, 32'h0, "rst_fault");
    expect_at(1, 0, K_READY, 32'h0, "rst_ready");
    expect_at(1, 0, K_DONE,  32'h0, "rst_done");
    expect_at(1, 0, K_WORDS, 32'h0, "rst_words");
    expect_at(1, 1, K_READY, 32'h0, "rst_ready_b");
    tick();
    rst_a = 1'b0; rst_b = 1'b0;
    ifa.pc_addr = 32'h2;

    // Two-word load; fetch issued in the DONE cycle sees new contents
    q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    load_a(q, 2, "ld2");
    fetch_a(32'h0, 32'h1234_5678, 1'b0, "ld2_pc0");
    expect_at(1, 0, K_DONE, 32'h0, "ld2_done_pulse_end");
    fetch_a(32'h4, 32'h9ABC_DEF0, 1'b0, "ld2_pc4");
    expect_at(1, 0, K_WORDS, 32'h2, "ld2_words_hold");

    // Partial final word padded with zeros
    q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    load_a(q, 2, "ld5");
    fetch_a(32'h4, 32'hEE00_0000, 1'b0, "ld5_pc4");
    fetch_a(32'h0, 32'hAABB_CCDD, 1'b0, "ld5_pc0");

    // Faults
    fetch_a(32'h2,         NOP, 1'b1, "mis2");
    fetch_a(32'h0000_1000, NOP, 1'b1, "oor_depth");
    fetch_a(32'h8000_0000, NOP, 1'b1, "oor_high");
    fetch_a(32'h4,         32'hEE00_0000, 1'b0, "after_fault");

    // 4-word instance: stream 20 bytes without ld_last
    tick();
    ifb.ld_start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      ifb.ld_start = 1'b0;
      ifb.ld_valid = 1'b1;
      ifb.ld_byte  = 8'(i);
      ifb.ld_last  = 1'b0;
      if (i == 15) begin
        expect_at(1, 1, K_DONE,  32'h1, "full_done");
        expect_at(1, 1, K_READY, 32'h0, "full_ready");
        expect_at(1, 1, K_WORDS, 32'h4, "full_words");
      end
      if (i == 16) begin
        expect_at(1, 1, K_DONE,  32'h0, "full_done_end");
        expect_at(1, 1, K_READY, 32'h0, "full_refuse");
        expect_at(1, 1, K_WORDS, 32'h4, "full_words_hold");
      end
    end
    fetch_b(32'h0,  32'h0001_0203, 1'b0, "full_w0");
    fetch_b(32'h4,  32'h0405_0607, 1'b0, "full_w1");
    fetch_b(32'h8,  32'h0809_0A0B, 1'b0, "full_w2");
    fetch_b(32'hC,  32'h0C0D_0E0F, 1'b0, "full_w3");
    fetch_b(32'h10, NOP,           1'b1, "full_oor");

    // Reset mid-load: abort without a done pulse, written word retained
    tick();
    ifa.ld_start = 1'b1;
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    for (int i = 0; i < 6; i++) begin
      tick();
      ifa.ld_start = 1'b0;
      ifa.ld_valid = 1'b1;
      ifa.ld_byte  = q[i];
      ifa.ld_last  = 1'b0;
    end
    tick();
    ifa.ld_valid = 1'b0;
    rst_a = 1'b1;
    expect_at(1, 0, K_WORDS, 32'h0, "abort_words");
    expect_at(1, 0, K_READY, 32'h0, "abort_ready");
    expect_at(1, 0, K_DONE,  32'h0, "abort_done");
    tick();
    rst_a = 1'b0;
    expect_at(1, 0, K_DONE,  32'h0, "abort_done1");
    expect_at(1, 0, K_READY, 32'h0, "abort_idle");
    tick();
    expect_at(1, 0, K_DONE,  32'h0, "abort_done2");
    expect_at(1, 0, K_WORDS, 32'h0, "abort_words2");
    fetch_a(32'h0, 32'h1122_3344, 1'b0, "abort_pc0");
    fetch_a(32'h4, 32'hEE00_0000, 1'b0, "abort_pc4");

    tick(); tick(); tick();
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain actual %0d pending required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
